lvds_tx_framer: RTL and testbench

Transmit-side word framer for one LVDS data lane, the far end of the link that our per-lane receive PHY and bitslip aligner terminate. Accepts 8-bit words over a valid/ready handshake and produces one 8-bit parallel word per `clk_div` cycle for an external 8:1 DDR OSERDES lane wrapper. Inserts a training pattern after reset or on request, so the receiver can run IDELAY/bitslip alignment, and an idle pattern when the source has no data. Optional P/N inversion compensates swapped board pairs.

---
 rtl/lvds_link_pkg.sv | 21 ++
 rtl/lvds_tx_framer.sv | 131 +++++++++++++
 tb/tb_lvds_tx_framer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/lvds_link_pkg.sv
// Shared definitions for the LVDS link: lane word width, the state encoding
// used by the transmit framer (and mirrored by the receive-side aligner), and
// the default training / idle words both ends agree on.
package lvds_link_pkg;

  localparam int LANE_W = 8;

  // Default training word: a 4-high / 4-low square wave gives the receiver
  // clean edges to centre its IDELAY on and an unambiguous bitslip target.
  localparam logic [LANE_W-1:0] TRAIN_WORD_DEF = 8'hF0;

  // Default idle word (K28.5-like comma) sent when no payload is available.
  localparam logic [LANE_W-1:0] IDLE_WORD_DEF = 8'hBC;

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_TRAIN = 2'd1,
    ST_RUN   = 2'd2
  } link_state_e;

endpackage

// File: rtl/lvds_tx_framer.sv
// Transmit-side word framer for one LVDS data lane.
//
// Produces one registered 8-bit word per clk_div cycle for a downstream 8:1
// DDR OSERDES. After reset it sends HOLD_CYCLES idle words, then a burst of
// TRAIN_LEN training words, then enters RUN where payload words are accepted
// over a valid/ready handshake (idle words fill the gaps). A train_req pulse
// starts or restarts a training burst. Every output word is optionally
// inverted to compensate a swapped P/N pair.
//
// Ports:
//   clk_div     in   parallel-word clock (OSERDES CLKDIV)
//   reset       in   asynchronous, active-high
//   train_req   in   single-cycle pulse: start/restart a training burst
//   s_data      in   payload word, bit 0 goes on the wire first
//   s_valid     in   s_data valid
//   s_ready     out  framer accepts s_data this cycle (RUN only)
//   dout        out  registered word to OSERDES D1..D8 (dout[0] -> D1)
//   training    out  high whenever the framer is not in RUN
//   word_count  out  accepted payload words, wraps modulo 2^16
module lvds_tx_framer
  import lvds_link_pkg::*;
#(
  parameter logic              flip_d      = 1'b0,
  parameter logic [LANE_W-1:0] TRAIN_WORD  = TRAIN_WORD_DEF,
  parameter logic [LANE_W-1:0] IDLE_WORD   = IDLE_WORD_DEF,
  parameter int unsigned       TRAIN_LEN   = 64,
  parameter int unsigned       HOLD_CYCLES = 4
) (
  input  logic              clk_div,
  input  logic              reset,
  input  logic              train_req,
  input  logic [LANE_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [LANE_W-1:0] dout,
  output logic              training,
  output logic [15:0]       word_count
);

  localparam int TCW = $clog2(TRAIN_LEN + 1);
  localparam int HCW = $clog2(HOLD_CYCLES + 1);

  localparam logic [TCW-1:0]    TRAIN_LAST = TCW'(TRAIN_LEN - 1);
  localparam logic [HCW-1:0]    HOLD_LAST  = HCW'(HOLD_CYCLES - 1);
  localparam logic [LANE_W-1:0] FLIP_MASK  = {LANE_W{flip_d}};

  link_state_e       state_q, state_d;
  logic [TCW-1:0]    train_cnt_q, train_cnt_d;
  logic [HCW-1:0]    hold_cnt_q, hold_cnt_d;
  logic [LANE_W-1:0] dout_q, dout_d;
  logic [15:0]       word_count_q, word_count_d;
  logic [LANE_W-1:0] word;

  always_ff @(posedge clk_div or posedge reset) begin
    if (reset) begin
      state_q      <= ST_HOLD;
      train_cnt_q  <= '0;
      hold_cnt_q   <= '0;
      dout_q       <= IDLE_WORD ^ FLIP_MASK;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      train_cnt_q  <= train_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      dout_q       <= dout_d;
      word_count_q <= word_count_d;
    end
  end

  // The word registered at each edge is chosen by the state during the cycle
  // before that edge, so a RUN -> TRAIN request still sends the word accepted
  // alongside it, and the burst itself starts on the following edge.
  always_comb begin
    state_d      = state_q;
    train_cnt_d  = train_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    word_count_d = word_count_q;
    word         = IDLE_WORD;

    unique case (state_q)
      ST_HOLD: begin
        // train_req is ignored here: a full burst follows anyway.
        word = IDLE_WORD;
        if (hold_cnt_q == HOLD_LAST) begin
          state_d     = ST_TRAIN;
          hold_cnt_d  = '0;
          train_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end

      ST_TRAIN: begin
        word = TRAIN_WORD;
        // A request restarts the count so TRAIN_LEN words follow the request.
        if (train_req) begin
          train_cnt_d = '0;
        end else if (train_cnt_q == TRAIN_LAST) begin
          state_d     = ST_RUN;
          train_cnt_d = '0;
        end else begin
          train_cnt_d = train_cnt_q + 1'b1;
        end
      end

      ST_RUN: begin
        if (s_valid) begin
          word         = s_data;
          word_count_d = word_count_q + 16'd1;
        end
        if (train_req) begin
          state_d     = ST_TRAIN;
          train_cnt_d = '0;
        end
      end

      default: begin
        state_d = ST_HOLD;
      end
    endcase

    dout_d = word ^ FLIP_MASK;
  end

  // Ready is a pure state decode: no combinational path from the inputs.
  assign s_ready    = (state_q == ST_RUN);
  assign training   = (state_q != ST_RUN);
  assign dout       = dout_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_lvds_tx_framer.sv
module tb_lvds_tx_framer;

  localparam int         H     = 4;
  localparam int         L     = 64;
  localparam logic [7:0] IDLE  = 8'hBC;
  localparam logic [7:0] TRW   = 8'hF0;

  logic       clk_div   = 1'b0;
  logic       reset     = 1'b1;
  logic       train_req = 1'b0;
  logic       s_valid   = 1'b0;
  logic [7:0] s_data    = 8'h00;

  logic       s_ready, training, s_ready_f, training_f;
  logic [7:0] dout, dout_f;
  logic [15:0] wc, wc_f;

  always #5 clk_div = ~clk_div;

  lvds_tx_framer #(.flip_d(1'b0)) dut (
    .clk_div(clk_div), .reset(reset), .train_req(train_req),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .dout(dout), .training(training), .word_count(wc)
  );

  lvds_tx_framer #(.flip_d(1'b1)) dut_f (
    .clk_div(clk_div), .reset(reset), .train_req(train_req),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_f),
    .dout(dout_f), .training(training_f), .word_count(wc_f)
  );

  typedef struct packed {
    logic [7:0]  word;
    logic        rdy;
    logic [15:0] cnt;
  } exp_t;

  exp_t        expq[$];
  bit          plan[$];   // pending forced words: 0 = idle (hold), 1 = training
  int unsigned acc_cnt;
  int          tests = 0;
  int          fails = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Reference model: after reset the link owes H idle words then L training
  // words; while anything is owed, no payload is taken.
  function automatic void model_reset();
    plan.delete();
    repeat (H) plan.push_back(1'b0);
    repeat (L) plan.push_back(1'b1);
    acc_cnt = 0;
  endfunction

  // Called at a negedge: drives inputs for the next posedge, pushes the
  // expected post-edge outputs, returns at the following negedge.
  task automatic cycle(input logic v, input logic [7:0] d, input logic rq);
    exp_t e;
    bit   k;
    s_valid   = v;
    s_data    = d;
    train_req = rq;
    if (plan.size() > 0) begin
      k = plan.pop_front();
      e.word = k ? TRW : IDLE;
      if (rq && k) begin
        plan.delete();
        repeat (L) plan.push_back(1'b1);
      end
    end else begin
      if (v) begin
        e.word = d;
        acc_cnt++;
      end else begin
        e.word = IDLE;
      end
      if (rq) repeat (L) plan.push_back(1'b1);
    end
    e.rdy = (plan.size() == 0);
    e.cnt = 16'(acc_cnt % 65536);
    expq.push_back(e);
    @(negedge clk_div);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    s_valid   = 1'b0;
    train_req = 1'b0;
    #1;
    chk("rst_dout",       dout,       IDLE);
    chk("rst_dout_flip",  dout_f,     8'h43);
    chk("rst_ready",      s_ready,    0);
    chk("rst_ready_flip", s_ready_f,  0);
    chk("rst_training",   training,   1);
    chk("rst_train_flip", training_f, 1);
    chk("rst_count",      wc,         0);
    chk("rst_count_flip", wc_f,       0);
    repeat (2) @(negedge clk_div);
    reset = 1'b0;
    model_reset();
  endtask

  // Monitor: compares every post-edge output against the scoreboard.
  initial begin
    exp_t m;
    forever begin
      @(posedge clk_div);
      #1;
      if (expq.size() > 0) begin
        m = expq.pop_front();
        chk("dout",          dout,       m.word);
        chk("dout_flip",     dout_f,     m.word ^ 8'hFF);
        chk("s_ready",       s_ready,    m.rdy);
        chk("s_ready_flip",  s_ready_f,  m.rdy);
        chk("training",      training,   !m.rdy);
        chk("word_count",    wc,         m.cnt);
        chk("word_count_fl", wc_f,       m.cnt);
      end
    end
  end

  initial begin
    @(negedge clk_div);
    do_reset();

    // Hold + first burst; a request during hold must not change anything.
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    repeat (H + L - 2) cycle(1'b0, 8'h00, 1'b0);

    // Back-to-back payload then a gap.
    cycle(1'b1, 8'h01, 1'b0);
    cycle(1'b1, 8'h02, 1'b0);
    cycle(1'b1, 8'h03, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    chk("count_after_3", wc, 3);

    // Request together with a valid word; the source keeps offering data.
    cycle(1'b1, 8'hA5, 1'b1);
    repeat (L + 4) cycle(1'b1, 8'($urandom), 1'b0);

    // Request restarted on training word 30.
    cycle(1'b0, 8'h00, 1'b1);
    repeat (29) cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    repeat (L + 3) cycle(1'b1, 8'($urandom), 1'b0);

    // Random traffic with occasional training requests.
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 49) == 0);

    // Mid-burst reset with a non-zero word count.
    cycle(1'b1, 8'h5A, 1'b1);
    repeat (10) cycle(1'b1, 8'($urandom), 1'b0);
    do_reset();

    // Word counter wrap: 65536 accepted words return it to zero.
    repeat (H + L) cycle(1'b0, 8'h00, 1'b0);
    repeat (65536) cycle(1'b1, 8'($urandom), 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    chk("wrap_count", wc, 0);

    repeat (2) @(negedge clk_div);
    chk("scoreboard_drained", expq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
